day_of_year_counter: RTL and testbench

//   Day-of-year source upstream of the month/day conversion stage. Debounces the step

---
 rtl/day_of_year_counter.sv | 139 +++++++++++++
 tb/tb_day_of_year_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/day_of_year_counter.sv
// Day-of-year counter: debounced step key plus auto-advance ticks, kept in binary and BCD.
// Wraps after day 365 (or 366 when leap is set) back to day 1.
`timescale 1ns/1ps
module day_of_year_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_step_n,
    input  logic       auto_en,
    input  logic       leap,
    output logic [8:0] day_bin,
    output logic [3:0] bcd_hun,
    output logic [3:0] bcd_ten,
    output logic [3:0] bcd_one,
    output logic       step_ack,
    output logic       wrap
);

    typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StRelWait} state_e;

    // Entry into a wait state is the first stable sample, so the counter stops one short.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, key_s;
    logic             press_evt, inc, at_last;
    logic [8:0]       day_q, last_day;
    logic [3:0]       hun_q, ten_q, one_q;
    logic             ack_q, wrap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 1'b1;
            key_s   <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            sync_q  <= key_step_n;
            key_s   <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!key_s) state_d = StPressWait;
            end
            StPressWait: begin
                if (key_s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d   = StHeld;
                    cnt_d     = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHeld: begin
                cnt_d = '0;
                if (key_s) state_d = StRelWait;
            end
            StRelWait: begin
                if (!key_s) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign inc      = press_evt | (tick & auto_en);
    assign last_day = leap ? 9'd366 : 9'd365;
    // >= so that day 366 still wraps after leap is lowered.
    assign at_last  = (day_q >= last_day);

    always_ff @(posedge clk) begin
        if (reset) begin
            day_q  <= 9'd1;
            hun_q  <= 4'd0;
            ten_q  <= 4'd0;
            one_q  <= 4'd1;
            ack_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ack_q  <= inc;
            wrap_q <= inc & at_last;
            if (inc) begin
                if (at_last) begin
                    day_q <= 9'd1;
                    hun_q <= 4'd0;
                    ten_q <= 4'd0;
                    one_q <= 4'd1;
                end else begin
                    day_q <= day_q + 9'd1;
                    if (one_q == 4'd9) begin
                        one_q <= 4'd0;
                        if (ten_q == 4'd9) begin
                            ten_q <= 4'd0;
                            hun_q <= hun_q + 4'd1;
                        end else begin
                            ten_q <= ten_q + 4'd1;
                        end
                    end else begin
                        one_q <= one_q + 4'd1;
                    end
                end
            end
        end
    end

    assign day_bin  = day_q;
    assign bcd_hun  = hun_q;
    assign bcd_ten  = ten_q;
    assign bcd_one  = one_q;
    assign step_ack = ack_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_day_of_year_counter.sv
// Bench for day_of_year_counter: run-length debounce model plus decimal-digit reference,
// checked every cycle, with literal expectations at the key points.
`timescale 1ns/1ps
module tb_day_of_year_counter;

    localparam int unsigned D = 4;

    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, key_step_n = 1'b1;
    logic       auto_en = 1'b0, leap = 1'b0;
    logic [8:0] day_bin;
    logic [3:0] bcd_hun, bcd_ten, bcd_one;
    logic       step_ack, wrap;

    int vectors = 0, miscompares = 0;
    int ack_total = 0, wrap_total = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    day_of_year_counter #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .key_step_n (key_step_n),
        .auto_en    (auto_en),
        .leap       (leap),
        .day_bin    (day_bin),
        .bcd_hun    (bcd_hun),
        .bcd_ten    (bcd_ten),
        .bcd_one    (bcd_one),
        .step_ack   (step_ack),
        .wrap       (wrap)
    );

    // Model: debounced level flips after D consecutive synced samples that disagree with it.
    logic m_s1 = 1'b1, m_s2 = 1'b1, m_deb = 1'b1;
    int   m_run = 0, m_day = 1;
    logic m_ack = 1'b0, m_wrap = 1'b0;
    wire  m_press = (m_s2 != m_deb) && (m_run == D - 1) && (m_s2 == 1'b0);
    wire  m_inc   = m_press || (tick && auto_en);
    wire [8:0] m_lim = leap ? 9'd366 : 9'd365;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 <= 1'b1; m_s2 <= 1'b1; m_deb <= 1'b1; m_run <= 0;
            m_day <= 1; m_ack <= 1'b0; m_wrap <= 1'b0;
        end else begin
            m_s1 <= key_step_n;
            m_s2 <= m_s1;
            if (m_s2 == m_deb) m_run <= 0;
            else if (m_run == D - 1) begin
                m_deb <= m_s2;
                m_run <= 0;
            end else m_run <= m_run + 1;
            m_ack  <= m_inc;
            m_wrap <= m_inc && (m_day >= int'(m_lim));
            if (m_inc) m_day <= (m_day >= int'(m_lim)) ? 1 : m_day + 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if (day_bin !== 9'(m_day) || bcd_hun !== 4'(m_day / 100)
                || bcd_ten !== 4'((m_day / 10) % 10) || bcd_one !== 4'(m_day % 10)
                || step_ack !== m_ack || wrap !== m_wrap) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got day=%0d bcd=%0d/%0d/%0d ack=%b wrap=%b, want day=%0d ack=%b wrap=%b",
                         $time, day_bin, bcd_hun, bcd_ten, bcd_one, step_ack, wrap,
                         m_day, m_ack, m_wrap);
            end
            vectors++;
            if (int'(bcd_hun) * 100 + int'(bcd_ten) * 10 + int'(bcd_one) != int'(day_bin)) begin
                miscompares++;
                $display("FAIL bcd_invariant t=%0t: bcd=%0d/%0d/%0d day=%0d",
                         $time, bcd_hun, bcd_ten, bcd_one, day_bin);
            end
            if (step_ack === 1'b1) ack_total++;
            if (wrap === 1'b1) wrap_total++;
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        @(negedge clk);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, w0, ack_at;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        check_lit("reset_day", int'(day_bin), 1);
        check_lit("reset_bcd", int'({bcd_hun, bcd_ten, bcd_one}), 'h001);
        check_lit("reset_ack", int'(step_ack), 0);
        check_lit("reset_wrap", int'(wrap), 0);
        check_lit("reset_model_day", m_day, 1);
        @(negedge clk);
        reset = 1'b0;

        // Single press: accepted D+1 edges after the first edge sampling the low key
        a0 = ack_total;
        @(negedge clk);
        key_step_n = 1'b0;
        ack_at = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (step_ack && ack_at < 0) ack_at = i;
        end
        check_lit("press_latency", ack_at, 5);
        check_lit("press_day", int'(day_bin), 2);
        @(negedge clk);
        key_step_n = 1'b1;
        repeat (20) @(negedge clk);
        check_lit("press_one_ack", ack_total - a0, 1);
        check_lit("release_day", int'(day_bin), 2);

        // Bounce shorter than the debounce window
        @(negedge clk); key_step_n = 1'b0;
        repeat (2) @(negedge clk); key_step_n = 1'b1;
        @(negedge clk); key_step_n = 1'b0;
        repeat (2) @(negedge clk); key_step_n = 1'b1;
        repeat (10) @(negedge clk);
        check_lit("bounce_day", int'(day_bin), 2);

        // Auto ticks and BCD carries
        do_reset();
        auto_en = 1'b1;
        run_ticks(98);
        check_lit("tick99_day", int'(day_bin), 99);
        check_lit("tick99_bcd", int'({bcd_hun, bcd_ten, bcd_one}), 'h099);
        run_ticks(1);
        check_lit("tick100_day", int'(day_bin), 100);
        check_lit("tick100_bcd", int'({bcd_hun, bcd_ten, bcd_one}), 'h100);
        auto_en = 1'b0;
        run_ticks(5);
        check_lit("auto_off_day", int'(day_bin), 100);

        // Wrap at 365 and 366, and leap dropped at 366
        do_reset();
        auto_en = 1'b1;
        leap = 1'b0;
        run_ticks(364);
        check_lit("d365_day", int'(day_bin), 365);
        check_lit("d365_bcd", int'({bcd_hun, bcd_ten, bcd_one}), 'h365);
        w0 = wrap_total;
        run_ticks(1);
        check_lit("wrap365_day", int'(day_bin), 1);
        check_lit("wrap365_pulses", wrap_total - w0, 1);
        leap = 1'b1;
        run_ticks(365);
        check_lit("d366_day", int'(day_bin), 366);
        w0 = wrap_total;
        run_ticks(1);
        check_lit("wrap366_day", int'(day_bin), 1);
        check_lit("wrap366_pulses", wrap_total - w0, 1);
        run_ticks(365);
        @(negedge clk);
        leap = 1'b0;
        repeat (3) @(negedge clk);
        check_lit("leap_drop_hold", int'(day_bin), 366);
        run_ticks(1);
        check_lit("leap_drop_wrap", int'(day_bin), 1);

        // Press and tick in the same cycle
        do_reset();
        run_ticks(9);
        check_lit("d10_day", int'(day_bin), 10);
        a0 = ack_total;
        @(negedge clk);
        key_step_n = 1'b0;
        repeat (5) @(negedge clk);
        tick = 1'b1;
        check_lit("collision_model_press", int'(m_press), 1);
        @(negedge clk);
        tick = 1'b0;
        key_step_n = 1'b1;
        repeat (10) @(negedge clk);
        check_lit("collision_day", int'(day_bin), 11);
        check_lit("collision_acks", ack_total - a0, 1);

        // Reset in the middle of a debounce discards the press
        @(negedge clk);
        key_step_n = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        key_step_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        a0 = ack_total;
        repeat (10) @(negedge clk);
        check_lit("midreset_day", int'(day_bin), 1);
        check_lit("midreset_acks", ack_total - a0, 0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
